// File: rtl/aligner_pkg.sv
// Shared definitions for the byte aligner: default training byte,
// FSM state encoding and confirmation counter width.
package aligner_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'h0F;

  localparam int CONF_W = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/byte_window_sel.sv
// Byte window selector: extracts the byte at a given bit offset from two
// concatenated raw words and flags every offset whose window equals SYNC.
module byte_window_sel
  import aligner_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic [15:0] cat,
  input  logic [2:0]  offset,
  output logic [7:0]  sel,
  output logic [7:0]  match
);

  // Offset-selected byte plus a parallel compare of all eight windows
  always_comb begin
    sel   = cat[offset +: 8];
    match = '0;
    for (int k = 0; k < 8; k++) begin
      match[k] = (cat[k +: 8] == SYNC);
    end
  end

endmodule

// File: rtl/byte_aligner.sv
// Byte aligner: hunts the SYNC byte over all bit offsets, confirms the
// offset over CONF_N consecutive words, then forwards re-aligned bytes.
module byte_aligner
  import aligner_pkg::*;
#(
  parameter logic [7:0] SYNC   = SYNC_DEFAULT,
  parameter int         CONF_N = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       RELOCK,
  input  logic       DIPUSH,
  input  logic [7:0] DIN,
  output logic       DOPUSH,
  output logic [7:0] DOUT,
  output logic       ALIGNED,
  output logic [2:0] OFFSET,
  output logic [7:0] SLIP_CNT
);

  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONF_N);

  state_t            state, state_nxt;
  logic [CONF_W-1:0] conf_cnt, conf_nxt, conf_inc;
  logic [7:0]        din_d1, din_nxt;
  logic              have_prev, have_nxt;
  logic [2:0]        offset_nxt;
  logic [7:0]        slip_nxt, dout_nxt;
  logic              dopush_nxt, aligned_nxt;
  logic [15:0]       cat;
  logic [7:0]        win_sel, win_match;
  logic              eval;

  // Saturating increment so the slip counter never wraps
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lowest matching offset wins when several windows hit
  function automatic logic [2:0] lowest_hit(input logic [7:0] m);
    logic [2:0] k_sel;
    k_sel = '0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) k_sel = 3'(k);
    end
    return k_sel;
  endfunction

  assign cat      = {DIN, din_d1};
  assign eval     = DIPUSH && have_prev;
  assign conf_inc = conf_cnt + 1'b1;

  byte_window_sel #(.SYNC(SYNC)) u_sel (
    .cat    (cat),
    .offset (OFFSET),
    .sel    (win_sel),
    .match  (win_match)
  );

  // Next-state and next-output logic; CLR dominates, RELOCK blocks evaluation
  always_comb begin
    state_nxt  = state;
    conf_nxt   = conf_cnt;
    offset_nxt = OFFSET;
    slip_nxt   = SLIP_CNT;
    dout_nxt   = DOUT;
    dopush_nxt = 1'b0;
    din_nxt    = din_d1;
    have_nxt   = have_prev;
    if (CLR) begin
      state_nxt  = HUNT;
      conf_nxt   = '0;
      offset_nxt = '0;
      slip_nxt   = '0;
      dout_nxt   = '0;
      din_nxt    = '0;
      have_nxt   = 1'b0;
    end else begin
      if (DIPUSH) begin
        din_nxt  = DIN;
        have_nxt = 1'b1;
      end
      if (RELOCK) begin
        state_nxt = HUNT;
        conf_nxt  = '0;
      end else if (eval) begin
        case (state)
          HUNT: begin
            if (|win_match) begin
              offset_nxt = lowest_hit(win_match);
              conf_nxt   = CONF_W'(1);
              state_nxt  = (CONF_N == 1) ? LOCKED : CONFIRM;
            end
          end
          CONFIRM: begin
            if (win_match[OFFSET]) begin
              conf_nxt = conf_inc;
              if (conf_inc == CONF_LAST) state_nxt = LOCKED;
            end else begin
              state_nxt = HUNT;
              slip_nxt  = sat_inc(SLIP_CNT);
            end
          end
          LOCKED: begin
            dout_nxt   = win_sel;
            dopush_nxt = 1'b1;
          end
          default: state_nxt = HUNT;
        endcase
      end
    end
    aligned_nxt = (state_nxt == LOCKED);
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= HUNT;
    else     state <= state_nxt;
  end

  // Counters, history word and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      conf_cnt  <= '0;
      din_d1    <= '0;
      have_prev <= 1'b0;
      OFFSET    <= '0;
      SLIP_CNT  <= '0;
      DOUT      <= '0;
      DOPUSH    <= 1'b0;
      ALIGNED   <= 1'b0;
    end else begin
      conf_cnt  <= conf_nxt;
      din_d1    <= din_nxt;
      have_prev <= have_nxt;
      OFFSET    <= offset_nxt;
      SLIP_CNT  <= slip_nxt;
      DOUT      <= dout_nxt;
      DOPUSH    <= dopush_nxt;
      ALIGNED   <= aligned_nxt;
    end
  end

endmodule
